// File: rtl/bus_arb_pkg.sv
// Shared bus definitions: requester index type and fixed port numbering.
package bus_arb_pkg;

    localparam int unsigned IDX_W = 1;

    typedef logic [IDX_W-1:0] port_idx_t;

    localparam port_idx_t PORT_HOST = 1'b0;
    localparam port_idx_t PORT_CORE = 1'b1;

endpackage

// File: rtl/bus_arb_if.sv
// Bundle of the two requester ports, the downstream bus and arbiter status.
// slave is the arbiter's view; master is the view of whatever surrounds it.
interface bus_arb_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             req0_ready;
    logic             req0_read;
    logic             req0_write;
    logic [31:0]      req0_address;
    logic [31:0]      req0_data;
    logic             res0_valid;
    logic [31:0]      res0_data;

    logic             req1_ready;
    logic             req1_read;
    logic             req1_write;
    logic [31:0]      req1_address;
    logic [31:0]      req1_data;
    logic             res1_valid;
    logic [31:0]      res1_data;

    logic             bus_req_ready;
    logic             bus_req_read;
    logic             bus_req_write;
    logic [31:0]      bus_req_address;
    logic [31:0]      bus_req_data;
    logic             bus_res_valid;
    logic [31:0]      bus_res_data;

    logic [CNT_W-1:0] outstanding;
    logic             orphan;

    modport slave (
        input  req0_read, req0_write, req0_address, req0_data,
        input  req1_read, req1_write, req1_address, req1_data,
        input  bus_req_ready, bus_res_valid, bus_res_data,
        output req0_ready, res0_valid, res0_data,
        output req1_ready, res1_valid, res1_data,
        output bus_req_read, bus_req_write, bus_req_address, bus_req_data,
        output outstanding, orphan
    );

    modport master (
        output req0_read, req0_write, req0_address, req0_data,
        output req1_read, req1_write, req1_address, req1_data,
        output bus_req_ready, bus_res_valid, bus_res_data,
        input  req0_ready, res0_valid, res0_data,
        input  req1_ready, res1_valid, res1_data,
        input  bus_req_read, bus_req_write, bus_req_address, bus_req_data,
        input  outstanding, orphan
    );

endinterface

// File: rtl/bus_arb_id_fifo.sv
// In-order FIFO of requester IDs for reads awaiting a response.
// DEPTH is a power of two, so the pointers wrap modulo DEPTH naturally.
module id_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 din,
    input  logic                 pop,
    output logic                 dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [PTR_W:0]   cnt_q;

    // Pointer and occupancy update; push+pop together leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + PTR_W'(1);
            if (pop)  rd_q <= rd_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read behind the write pointer.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/bus_arb.sv
// Two-port round-robin bus arbiter with in-order read response routing.
module bus_arb
    import bus_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    bus_arb_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             any0;
    logic             any1;
    port_idx_t        grant;
    port_idx_t        last_q;
    logic             g_read;
    logic             g_write;
    logic             blocked;
    logic             accept;
    logic             push;
    logic             pop;
    logic             head;
    logic [CNT_W-1:0] count;
    logic             orphan_q;

    // Grant: sole requester wins; on a tie, the one not granted last.
    always_comb begin
        any0 = bus.req0_read | bus.req0_write;
        any1 = bus.req1_read | bus.req1_write;
        if (any0 && any1) begin
            grant = (last_q == PORT_HOST) ? PORT_CORE : PORT_HOST;
        end else if (any1) begin
            grant = PORT_CORE;
        end else begin
            grant = PORT_HOST;
        end
    end

    // Downstream mux, read throttling when the ID FIFO is full, and ready.
    always_comb begin
        g_read  = (grant == PORT_CORE) ? bus.req1_read  : bus.req0_read;
        g_write = (grant == PORT_CORE) ? bus.req1_write : bus.req0_write;
        // Full means blocked even if a response frees a slot this cycle.
        blocked = g_read && (count == CNT_W'(DEPTH));

        bus.bus_req_read    = g_read & ~blocked;
        bus.bus_req_write   = g_write;
        bus.bus_req_address = (grant == PORT_CORE) ? bus.req1_address : bus.req0_address;
        bus.bus_req_data    = (grant == PORT_CORE) ? bus.req1_data    : bus.req0_data;

        bus.req0_ready = bus.bus_req_ready & (grant == PORT_HOST) & ~blocked;
        bus.req1_ready = bus.bus_req_ready & (grant == PORT_CORE) & ~blocked;

        accept = bus.bus_req_ready & ((g_read & ~blocked) | g_write);
        push   = accept & g_read;
    end

    // Response routing: zero-latency pop of the head ID when a read is pending.
    always_comb begin
        pop             = bus.bus_res_valid & (count != '0);
        bus.res0_valid  = pop & (head == PORT_HOST);
        bus.res1_valid  = pop & (head == PORT_CORE);
        bus.res0_data   = bus.bus_res_data;
        bus.res1_data   = bus.bus_res_data;
        bus.outstanding = count;
        bus.orphan      = orphan_q;
    end

    // Last-granted tracking; reset to core so the host wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= PORT_CORE;
        end else if (accept) begin
            last_q <= grant;
        end
    end

    // Sticky flag for a response arriving with nothing outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            orphan_q <= 1'b0;
        end else if (bus.bus_res_valid && (count == '0)) begin
            orphan_q <= 1'b1;
        end
    end

    id_fifo #(
        .DEPTH (DEPTH)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (grant),
        .pop   (pop),
        .dout  (head),
        .count (count)
    );

endmodule

// File: tb/tb_bus_arb.sv
// Directed table-driven bench for bus_arb with hand sequences for reset corners.
module tb_bus_arb;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] K0 = 32'hDA7A_0000;
    localparam logic [31:0] K1 = 32'hC0DE_0000;

    typedef struct {
        bit          r0, w0, r1, w1, br, rv;
        logic [31:0] a0, a1, rd;
        bit          g, rdy0, rdy1, brd, bwr, rs0, rs1, orph;
        int          out;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    bus_arb_if #(.DEPTH(DEPTH)) bif ();

    bus_arb #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int r0, w0, a0, r1, w1, a1, br, rv, rd,
                                input int g, rdy0, rdy1, brd, bwr, rs0, rs1, out, orph);
        vec_t v;
        v.r0 = (r0 != 0); v.w0 = (w0 != 0); v.a0 = 32'(a0);
        v.r1 = (r1 != 0); v.w1 = (w1 != 0); v.a1 = 32'(a1);
        v.br = (br != 0); v.rv = (rv != 0); v.rd = 32'(rd);
        v.g = (g != 0); v.rdy0 = (rdy0 != 0); v.rdy1 = (rdy1 != 0);
        v.brd = (brd != 0); v.bwr = (bwr != 0); v.rs0 = (rs0 != 0); v.rs1 = (rs1 != 0);
        v.out = out; v.orph = (orph != 0);
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input bit exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bif.req0_read = 1'b0; bif.req0_write = 1'b0; bif.req0_address = '0; bif.req0_data = '0;
        bif.req1_read = 1'b0; bif.req1_write = 1'b0; bif.req1_address = '0; bif.req1_data = '0;
        bif.bus_req_ready = 1'b0; bif.bus_res_valid = 1'b0; bif.bus_res_data = '0;
    endtask

    // Apply one vector between clock edges and compare all outputs before the next edge.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        bif.req0_read = v.r0; bif.req0_write = v.w0;
        bif.req0_address = v.a0; bif.req0_data = v.a0 ^ K0;
        bif.req1_read = v.r1; bif.req1_write = v.w1;
        bif.req1_address = v.a1; bif.req1_data = v.a1 ^ K1;
        bif.bus_req_ready = v.br; bif.bus_res_valid = v.rv; bif.bus_res_data = v.rd;
        #1;
        chk1({tag, " req0_ready"}, bif.req0_ready, v.rdy0);
        chk1({tag, " req1_ready"}, bif.req1_ready, v.rdy1);
        chk1({tag, " bus_req_read"}, bif.bus_req_read, v.brd);
        chk1({tag, " bus_req_write"}, bif.bus_req_write, v.bwr);
        chk32({tag, " bus_req_address"}, bif.bus_req_address, v.g ? v.a1 : v.a0);
        chk32({tag, " bus_req_data"}, bif.bus_req_data, v.g ? (v.a1 ^ K1) : (v.a0 ^ K0));
        chk1({tag, " res0_valid"}, bif.res0_valid, v.rs0);
        chk1({tag, " res1_valid"}, bif.res1_valid, v.rs1);
        chk32({tag, " res0_data"}, bif.res0_data, v.rd);
        chk32({tag, " res1_data"}, bif.res1_data, v.rd);
        chk32({tag, " outstanding"}, 32'(bif.outstanding), 32'(v.out));
        chk1({tag, " orphan"}, bif.orphan, v.orph);
    endtask

    // Reset pulse; response strobed while in reset must not produce res*_valid.
    task automatic do_reset(input string tag);
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        #1;
        chk32({tag, " outstanding in reset"}, 32'(bif.outstanding), 32'd0);
        chk1({tag, " orphan in reset"}, bif.orphan, 1'b0);
        bif.bus_res_valid = 1'b1;
        #1;
        chk1({tag, " res0_valid in reset"}, bif.res0_valid, 1'b0);
        chk1({tag, " res1_valid in reset"}, bif.res1_valid, 1'b0);
        @(negedge clk);
        bif.bus_res_valid = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        vec_t tbl[$];
        drive_idle();
        do_reset("init");

        //                r0 w0 a0     r1 w1 a1     br rv rd        g rdy0 rdy1 brd bwr rs0 rs1 out orph
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,     1, 0, 0,        0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 'h10,  1, 0, 'h20,  1, 0, 0,        0, 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 'h10,  1, 0, 'h20,  1, 0, 0,        1, 0, 1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 'h10,  1, 0, 'h20,  1, 0, 0,        0, 1, 0, 1, 0, 0, 0, 2, 0));
        tbl.push_back(mk(1, 0, 'h10,  1, 0, 'h20,  1, 0, 0,        1, 0, 1, 1, 0, 0, 0, 3, 0));
        tbl.push_back(mk(1, 0, 'h10,  1, 0, 'h20,  1, 1, 'h11,     0, 0, 0, 0, 0, 1, 0, 4, 0));
        tbl.push_back(mk(1, 0, 'h10,  1, 0, 'h20,  1, 0, 0,        0, 1, 0, 1, 0, 0, 0, 3, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,     1, 1, 'h22,     0, 1, 0, 0, 0, 0, 1, 4, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,     1, 1, 'h33,     0, 1, 0, 0, 0, 1, 0, 3, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,     1, 1, 'h44,     0, 1, 0, 0, 0, 0, 1, 2, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,     1, 1, 'h55,     0, 1, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 1, 'h30,  0, 0, 0,     0, 0, 0,        0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'h30,  0, 0, 0,     1, 0, 0,        0, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 1, 'h40,  1, 0, 0,        1, 0, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'h50,  0, 1, 'h60,  1, 0, 0,        0, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'h50,  0, 1, 'h60,  1, 0, 0,        1, 0, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,     1, 0, 'h100, 1, 0, 0,        1, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 'h200, 0, 0, 0,     1, 0, 0,        0, 1, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,     1, 1, 'hAAAA,   0, 1, 0, 0, 0, 0, 1, 2, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,     1, 1, 'hBBBB,   0, 1, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,     1, 1, 'hCCCC,   0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,     1, 0, 0,        0, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,     1, 1, 'hDDDD,   0, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 'h70,  0, 1, 'h80,  1, 0, 0,        1, 0, 1, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 'h70,  0, 1, 'h80,  1, 0, 0,        0, 1, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,     1, 0, 0,        0, 1, 0, 0, 0, 0, 0, 1, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], $sformatf("t%0d", i));
        end

        // Full FIFO: fifth read blocked, write from the other port still accepted,
        // then a response coinciding with a read still blocks that read.
        do_reset("full");
        for (int i = 0; i < 4; i++) begin
            run_vec(mk(1, 0, 'h300, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, i, 0),
                    $sformatf("fill%0d", i));
        end
        run_vec(mk(1, 0, 'h300, 0, 0, 0,     1, 0, 0,     0, 0, 0, 0, 0, 0, 0, 4, 0), "blk");
        run_vec(mk(1, 0, 'h300, 0, 1, 'h400, 1, 0, 0,     1, 0, 1, 0, 1, 0, 0, 4, 0), "blk_wr");
        run_vec(mk(1, 0, 'h300, 0, 0, 0,     1, 1, 'h77,  0, 0, 0, 0, 0, 1, 0, 4, 0), "blk_pop");
        run_vec(mk(1, 0, 'h300, 0, 0, 0,     1, 0, 0,     0, 1, 0, 1, 0, 0, 0, 3, 0), "unblk");
        run_vec(mk(0, 0, 0,     0, 0, 0,     1, 0, 0,     0, 1, 0, 0, 0, 0, 0, 4, 0), "refull");

        // Reset taken mid-operation discards two in-flight reads.
        do_reset("mid");
        run_vec(mk(0, 0, 0, 1, 0, 'h500, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0), "rd_a");
        run_vec(mk(0, 0, 0, 1, 0, 'h500, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0), "rd_b");
        @(negedge clk);
        drive_idle();
        #1;
        chk32("pre_rst outstanding", 32'(bif.outstanding), 32'd2);
        #1;
        rst = 1'b1;
        #1;
        chk32("async_rst outstanding", 32'(bif.outstanding), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(mk(0, 0, 0, 0, 0, 0, 1, 1, 'h99, 0, 1, 0, 0, 0, 0, 0, 0, 0), "late_res");
        run_vec(mk(0, 0, 0, 0, 0, 0, 1, 0, 0,    0, 1, 0, 0, 0, 0, 0, 0, 1), "late_orph");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
